fetch_pc_ctrl: RTL and testbench

Sequences the program counter and instruction fetch for the 5-stage MIPS pipeline. Owns the PC register and the instruction-memory request handshake. Produces the F/D pipeline register: instruction, PC and PC+4. Accepts stall from the hazard unit and taken-branch/jump targets from the D-stage next-PC logic, with MIPS delay-slot semantics.

---
 rtl/fetch_pc_ctrl_if.sv | 29 ++
 rtl/fetch_pc_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - instruction-memory request/response bundle
//
// Purpose: carries one fetch request at a time from the PC sequencer to
// instruction memory, and carries the response back.
// Signals:
//   imem_req_o   - fetch request (driven by the fetch unit)
//   imem_addr_o  - word-aligned fetch address (driven by the fetch unit)
//   imem_ready_i - response valid; completes the current request (memory)
//   imem_rdata_i - fetched instruction word (memory)
interface fetch_pc_ctrl_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - PC sequencer and instruction fetch for a 5-stage MIPS pipe
//
// Purpose: owns the PC and the imem handshake, fills the F/D register
// (instruction, PC, PC+4), honours hazard stalls and D-stage redirects with
// delay-slot semantics. pc_q advances exactly once per instruction that
// enters the F/D slot.
// Ports:
//   clk              - system clock, rising edge
//   reset_n          - asynchronous active-low reset
//   stall_i          - D stage holds; F/D slot not consumed this cycle
//   redirect_valid_i - taken branch / jump in D (sampled only when stall_i=0)
//   redirect_pc_i    - redirect target address
//   imem             - instruction-memory handshake (master side)
//   if_valid_o       - F/D slot holds a valid instruction
//   if_instr_o       - F/D instruction
//   if_pc_o          - F/D instruction address
//   if_pc4_o         - if_pc_o + 4 (PC_D)
//   busy_o           - high in SKID or while a redirect is pending
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [31:0]           redirect_pc_i,
  fetch_pc_ctrl_if.master       imem,
  output logic                  if_valid_o,
  output logic [31:0]           if_instr_o,
  output logic [31:0]           if_pc_o,
  output logic [31:0]           if_pc4_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_pc;
  logic [31:0] r_skid_instr;

  logic        w_room;
  logic        w_enter;
  logic        w_to_skid;
  logic [31:0] w_enter_instr;
  logic [31:0] w_next_pc;
  logic        w_redirect;

  // A redirect is only meaningful when D actually advances.
  assign w_redirect = redirect_valid_i && !stall_i;
  assign w_room     = !r_if_valid || !stall_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_enter       = 1'b0;
    w_to_skid     = 1'b0;
    w_enter_instr = imem.imem_rdata_i;
    case (r_state)
      ST_INIT: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.imem_ready_i) begin
          if (w_room) begin
            w_enter = 1'b1;
          end else begin
            w_to_skid   = 1'b1;
            w_state_nxt = ST_SKID;
          end
        end
      end
      ST_SKID: begin
        w_enter_instr = r_skid_instr;
        if (!stall_i) begin
          w_enter     = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (w_redirect) begin
      w_next_pc = redirect_pc_i;
    end else if (r_pend_valid) begin
      w_next_pc = r_pend_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_INIT;
      r_pc         <= RESET_PC;
      r_if_valid   <= 1'b0;
      r_if_instr   <= 32'd0;
      r_if_pc      <= 32'd0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
    end else begin
      r_state <= w_state_nxt;

      if (w_to_skid) begin
        r_skid_instr <= imem.imem_rdata_i;
      end

      if (w_enter) begin
        r_if_valid   <= 1'b1;
        r_if_instr   <= w_enter_instr;
        r_if_pc      <= r_pc;
        r_pc         <= w_next_pc;
        // Any pending target is consumed (or superseded by a newer redirect)
        // the moment the delay-slot instruction lands.
        r_pend_valid <= 1'b0;
      end else begin
        if (!stall_i) begin
          r_if_valid <= 1'b0;
        end
        // Redirect seen while the delay slot is still in flight: remember the
        // target so it is applied when that instruction finally enters.
        if (w_redirect) begin
          r_pend_valid <= 1'b1;
          r_pend_pc    <= redirect_pc_i;
        end
      end
    end
  end

  assign imem.imem_req_o  = (r_state == ST_FETCH);
  assign imem.imem_addr_o = r_pc;

  assign if_valid_o = r_if_valid;
  assign if_instr_o = r_if_instr;
  assign if_pc_o    = r_if_pc;
  assign if_pc4_o   = r_if_pc + 32'd4;
  assign busy_o     = (r_state == ST_SKID) || r_pend_valid;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - directed self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc4_o;
  logic        busy_o;
  logic        mem_ready;

  int n_tests;
  int n_fail;

  fetch_pc_ctrl_if imem_bus ();

  // Memory model: the instruction word at address A is ~A.
  assign imem_bus.imem_ready_i = mem_ready;
  assign imem_bus.imem_rdata_i = ~imem_bus.imem_addr_o;

  fetch_pc_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem             (imem_bus.master),
    .if_valid_o       (if_valid_o),
    .if_instr_o       (if_instr_o),
    .if_pc_o          (if_pc_o),
    .if_pc4_o         (if_pc4_o),
    .busy_o           (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in FETCH with imem_addr_o = RESET_PC and an empty slot.
  task automatic do_reset();
    mem_ready        = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'd0;
    reset_n          = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    reset_n          = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'd0;
    mem_ready        = 1'b0;

    // Reset values
    #3;
    check_val("rst_if_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("rst_if_pc", if_pc_o, 32'd0);
    check_val("rst_if_instr", if_instr_o, 32'd0);
    check_val("rst_if_pc4", if_pc4_o, 32'd4);
    check_val("rst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);

    // 1: zero-wait sequential fetch
    do_reset();
    check_val("t1_req", {31'd0, imem_bus.imem_req_o}, 32'd1);
    check_val("t1_addr0", imem_bus.imem_addr_o, 32'h0000_3000);
    check_val("t1_valid0", {31'd0, if_valid_o}, 32'd0);
    mem_ready = 1'b1;
    tick();
    check_val("t1_valid1", {31'd0, if_valid_o}, 32'd1);
    check_val("t1_pc1", if_pc_o, 32'h0000_3000);
    check_val("t1_instr1", if_instr_o, ~32'h0000_3000);
    check_val("t1_pc4_1", if_pc4_o, 32'h0000_3004);
    check_val("t1_addr1", imem_bus.imem_addr_o, 32'h0000_3004);

    // 2: branch at 0x3000 in D while 0x3004 completes
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_3100;
    tick();
    redirect_valid_i = 1'b0;
    check_val("t2_slot_pc", if_pc_o, 32'h0000_3004);
    check_val("t2_slot_instr", if_instr_o, ~32'h0000_3004);
    check_val("t2_addr", imem_bus.imem_addr_o, 32'h0000_3100);
    tick();
    check_val("t2_tgt_pc", if_pc_o, 32'h0000_3100);
    check_val("t2_addr_seq", imem_bus.imem_addr_o, 32'h0000_3104);

    // 3: redirect during a 3-cycle wait on 0x3004
    do_reset();
    mem_ready = 1'b1;
    tick();
    mem_ready        = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_3100;
    tick();
    redirect_valid_i = 1'b0;
    check_val("t3_bubble", {31'd0, if_valid_o}, 32'd0);
    check_val("t3_busy", {31'd0, busy_o}, 32'd1);
    check_val("t3_addr_w1", imem_bus.imem_addr_o, 32'h0000_3004);
    tick();
    check_val("t3_addr_w2", imem_bus.imem_addr_o, 32'h0000_3004);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_val("t3_valid", {31'd0, if_valid_o}, 32'd1);
    check_val("t3_slot_pc", if_pc_o, 32'h0000_3004);
    check_val("t3_addr_tgt", imem_bus.imem_addr_o, 32'h0000_3100);
    check_val("t3_busy_clr", {31'd0, busy_o}, 32'd0);

    // 4: stall with ready -> SKID, release with redirect
    do_reset();
    mem_ready = 1'b1;
    tick();
    tick();
    stall_i = 1'b1;
    tick();
    check_val("t4_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    check_val("t4_busy", {31'd0, busy_o}, 32'd1);
    check_val("t4_pc_hold", imem_bus.imem_addr_o, 32'h0000_3008);
    check_val("t4_slot_hold", if_pc_o, 32'h0000_3004);
    tick();
    check_val("t4_req_hold", {31'd0, imem_bus.imem_req_o}, 32'd0);
    stall_i          = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_3200;
    tick();
    redirect_valid_i = 1'b0;
    mem_ready        = 1'b0;
    check_val("t4_slot_pc", if_pc_o, 32'h0000_3008);
    check_val("t4_slot_instr", if_instr_o, ~32'h0000_3008);
    check_val("t4_addr_tgt", imem_bus.imem_addr_o, 32'h0000_3200);
    check_val("t4_req_back", {31'd0, imem_bus.imem_req_o}, 32'd1);
    check_val("t4_busy_clr", {31'd0, busy_o}, 32'd0);

    // 5: async reset mid-wait with a pending redirect
    do_reset();
    mem_ready = 1'b1;
    tick();
    mem_ready        = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0000_3100;
    tick();
    redirect_valid_i = 1'b0;
    check_val("t5_pend", {31'd0, busy_o}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("t5_rst_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("t5_rst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    check_val("t5_rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("t5_rst_pc4", if_pc4_o, 32'd4);
    mem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check_val("t5_init_ign", {31'd0, if_valid_o}, 32'd0);
    check_val("t5_addr0", imem_bus.imem_addr_o, 32'h0000_3000);
    tick();
    check_val("t5_slot_pc", if_pc_o, 32'h0000_3000);
    check_val("t5_no_pend", imem_bus.imem_addr_o, 32'h0000_3004);

    // 6: wrap past the top of the address space
    do_reset();
    mem_ready = 1'b1;
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'hFFFF_FFFC;
    tick();
    redirect_valid_i = 1'b0;
    check_val("t6_addr_top", imem_bus.imem_addr_o, 32'hFFFF_FFFC);
    tick();
    check_val("t6_slot_top", if_pc_o, 32'hFFFF_FFFC);
    check_val("t6_pc4_wrap", if_pc4_o, 32'h0000_0000);
    check_val("t6_addr_wrap", imem_bus.imem_addr_o, 32'h0000_0000);
    mem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
